// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   8N1 serial receive stage feeding the UART command parser.
//   The asynchronous ser_in line is synchronised first. Each bit is then
//   sampled at its midpoint, using the OVERSAMPLE x baud enable from the
//   baud generator.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   baud_tick    one-clk enable at OVERSAMPLE x baud rate
//   ser_in       asynchronous serial line, idle high
//   rx_data      last good byte (LSB received first), held until next good frame
//   new_rx_data  one-clk strobe: rx_data has just been updated
//   frame_err    one-clk strobe: stop bit sampled low
//   rx_busy      high whenever the receiver is not idle
//   line_break   level: all-zero frame with low stop, held until the line returns high
module uart_rx_frame #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       ser_in,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
  output logic       rx_busy,
  output logic       line_break
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;

  state_t        r_state,    w_state_nxt;
  logic [CW-1:0] r_tick_cnt, w_tick_nxt;
  logic [2:0]    r_bit_idx,  w_bit_nxt;
  logic [7:0]    r_shift,    w_shift_nxt;
  logic [7:0]    r_rx_data,  w_data_nxt;
  logic          r_new,      w_new_nxt;
  logic          r_ferr,     w_ferr_nxt;
  logic          r_break,    w_break_nxt;

  // Metastability synchroniser. It resets to the idle (high) level so that
  // reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ser_in};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_new      <= 1'b0;
      r_ferr     <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_data_nxt;
      r_new      <= w_new_nxt;
      r_ferr     <= w_ferr_nxt;
      r_break    <= w_break_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_rx_data;
    w_new_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_break_nxt = r_break;

    case (r_state)
      // Start-edge detection runs on every clk, not only on baud_tick.
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
        end
      end

      // Confirm the start bit at its midpoint. A high level here means a glitch.
      S_START: begin
        if (baud_tick) begin
          if (r_tick_cnt == MID) begin
            w_tick_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      // Counting from the start midpoint, a full bit period lands on each
      // data bit midpoint.
      S_DATA: begin
        if (baud_tick) begin
          if (r_tick_cnt == LAST) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rx_s, r_shift[7:1]};
            w_bit_nxt   = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      // Return to IDLE at the stop-bit midpoint, so a back-to-back start
      // edge half a bit later is still caught.
      S_STOP: begin
        if (baud_tick) begin
          if (r_tick_cnt == LAST) begin
            w_tick_nxt = '0;
            if (w_rx_s) begin
              w_data_nxt  = r_shift;
              w_new_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_WAIT_IDLE;
              if (r_shift == 8'h00) begin
                w_break_nxt = 1'b1;
              end
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      // After a framing error, wait on every clk for the line to go idle.
      S_WAIT_IDLE: begin
        if (w_rx_s) begin
          w_break_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rx_data     = r_rx_data;
  assign new_rx_data = r_new;
  assign frame_err   = r_ferr;
  assign line_break  = r_break;
  assign rx_busy     = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receive stage that sits directly upstream of the UART command parser inside the UART top.
- Deserialises 8N1 frames from the synchronised serial line, using the baud generator's oversample enable.
- Presents each received byte as rx_data with a one-cycle new_rx_data strobe; this is the byte stream the parser consumes.
- Flags framing errors and line breaks so the parser can drop partial commands.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, range 8..32.
- SYNC_STAGES, 2, flip-flops in the ser_in metastability synchroniser; range 2..3.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk enable at OVERSAMPLE x baud rate, from the baud generator
- ser_in  input  1  asynchronous serial line; idle high
- rx_data  output  8  last received byte; LSB received first
- new_rx_data  output  1  one-clk strobe, rx_data valid
- frame_err  output  1  one-clk strobe, stop bit sampled low
- rx_busy  output  1  high whenever state != IDLE
- line_break  output  1  level; high while a break (all-zero frame with low stop) persists

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rx_data=8'h00; new_rx_data=0; frame_err=0; rx_busy=0; line_break=0.
  - Synchroniser flops=1; state=IDLE; tick_cnt=0; bit_idx=0.
- Synchroniser: ser_in passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits and advances only on baud_tick. It wraps at OVERSAMPLE-1 -> 0.
  - MID = OVERSAMPLE/2-1.
- FSM (transitions are evaluated only on clk edges with baud_tick=1, except where noted):
  - IDLE:
    - If rx_s==0: go to START, tick_cnt=0.
    - A falling edge is detected on any clk, with or without baud_tick.
  - START:
    - At tick_cnt==MID, rx_s==0: go to DATA, tick_cnt=0, bit_idx=0.
    - At tick_cnt==MID, rx_s==1: false start (glitch), go to IDLE. No strobe is generated.
  - DATA:
    - At tick_cnt==OVERSAMPLE-1: shift rx_s into the MSB of shift_reg (right shift) and increment bit_idx.
    - After the 8th sample: go to STOP, tick_cnt=0.
  - STOP, at tick_cnt==OVERSAMPLE-1:
    - rx_s==1:
      - rx_data<=shift_reg and new_rx_data=1 for exactly one clk.
      - Go to IDLE.
    - rx_s==0:
      - frame_err=1 for one clk; rx_data is NOT updated.
      - If shift_reg==8'h00, set line_break=1.
      - Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 (checked every clk). Then clear line_break and go to IDLE.
- Latency: new_rx_data rises on the clk edge that samples the stop bit midpoint. That edge is OVERSAMPLE*9+MID+1 baud_ticks after the tick that detected the start edge.
- new_rx_data and frame_err are mutually exclusive and never high in consecutive cycles from the same frame.
- rx_data holds its value until the next valid frame.
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit midpoint, so a start edge arriving half a bit later is captured.
  - No minimum idle time is required.
- Reset mid-frame: state returns to IDLE immediately. No strobe is issued and the partial shift_reg is discarded.
- baud_tick held low: the FSM freezes in its current state and the counters hold.

Test Plan:
1. Send 0x55 at OVERSAMPLE=16 with a baud_tick every 4 clk -> one new_rx_data pulse, rx_data=8'h55, frame_err=0, rx_busy drops on the same edge.
2. Send 0xA3 then 0x0F back-to-back with zero idle time -> two strobes, rx_data=8'hA3 then 8'h0F, no frame_err.
3. Hold ser_in low for 5 baud_ticks then return high (glitch) -> no new_rx_data, no frame_err, FSM in IDLE after tick 7, rx_data unchanged.
4. Send 0x3C with the stop bit forced low -> frame_err single pulse, no new_rx_data, rx_data keeps its previous value (8'h0F); return high -> rx_busy=0.
5. Hold ser_in low for 3 frame times (break) -> frame_err once, line_break=1 until the line goes high, then line_break=0; next byte 0x7E received correctly.
6. Assert rst_n low during bit 4 of 0x99, release, then send 0x42 -> no strobe for 0x99, all outputs at reset values, then rx_data=8'h42 with one strobe.
